// File: rtl/mdu_pkg.sv
// Shared constants and types for the multiply/divide unit controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mdu_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } state_t;

    // Signed variants take absolute values up front and fix the sign at the end.
    function automatic logic is_signed_funct(input logic [5:0] f);
        return (f == F_MULT) || (f == F_DIV);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Decode-side issue port and result/HI-LO view of the multiply/divide unit.
// Latency: n/a (signal bundle only).
// Backpressure: op_ready gates op_valid; results are pulses with no ready.
interface mdu_if #(parameter int WIDTH = 32);

    logic             op_valid;
    logic [5:0]       op_funct;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [4:0]       rd;
    logic             op_ready;
    logic             busy;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic [4:0]       res_rd;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // The MDU side.
    modport slave (
        input  op_valid, op_funct, rs_val, rt_val, rd,
        output op_ready, busy, res_valid, res_data, res_rd, div_by_zero, hi, lo
    );

    // The decode side.
    modport master (
        output op_valid, op_funct, rs_val, rt_val, rd,
        input  op_ready, busy, res_valid, res_data, res_rd, div_by_zero, hi, lo
    );

endinterface

// File: rtl/mdu_iter.sv
// One radix-2 step: shift-add multiply (right shift) or restoring divide (left shift).
// Latency: combinational.
// Backpressure: none; the controller decides when to register the result.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_acc,   // product upper half / partial remainder
    input  logic [WIDTH-1:0] i_q,     // multiplier bits / dividend-quotient bits
    input  logic [WIDTH-1:0] i_opnd,  // multiplicand / divisor
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH-1:0] w_diff;
    logic             w_fits;

    // The partial remainder is always below the divisor, so the shifted value
    // needs one extra bit but the difference, when taken, fits in WIDTH bits.
    always_comb begin
        w_sum    = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_opnd} : '0);
        w_rem_sh = {i_acc, i_q[WIDTH-1]};
        w_fits   = (w_rem_sh >= {1'b0, i_opnd});
        w_diff   = w_rem_sh[WIDTH-1:0] - i_opnd;
        if (i_div) begin
            o_acc = w_fits ? w_diff : w_rem_sh[WIDTH-1:0];
            o_q   = {i_q[WIDTH-2:0], w_fits};
        end else begin
            o_acc = w_sum[WIDTH:1];
            o_q   = {w_sum[0], i_q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: owns HI/LO, sequences WIDTH iterative steps plus a sign-fix cycle.
// Latency: MULT/DIV update HI/LO WIDTH+1 cycles after accept; MFHI/MFLO result the cycle after accept.
// Backpressure: op_ready is high only in IDLE; requests wait (including MFHI/MFLO) while busy.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic rst_n,
    mdu_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_res_dat;
    logic [4:0]       r_res_rd;
    logic             r_res_vld;
    logic             r_neg_q;   // negate product / quotient in FIX
    logic             r_neg_r;   // negate remainder in FIX
    logic             r_dz;
    logic             r_is_div;

    logic             w_take;
    logic             w_is_mul;
    logic             w_is_div;
    logic             w_is_mf;
    logic             w_sgn;
    logic             w_step_div;
    logic [WIDTH-1:0] w_rs_abs;
    logic [WIDTH-1:0] w_rt_abs;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic [2*WIDTH-1:0] w_prod_neg;
    logic [WIDTH-1:0] w_hi_fix;
    logic [WIDTH-1:0] w_lo_fix;

    assign w_take     = bus.op_valid && (r_state == ST_IDLE);
    assign w_step_div = (r_state == ST_DIV);

    // Decode the accepted funct and form operand magnitudes for signed ops.
    always_comb begin
        w_is_mul = w_take && ((bus.op_funct == F_MULT) || (bus.op_funct == F_MULTU));
        w_is_div = w_take && ((bus.op_funct == F_DIV)  || (bus.op_funct == F_DIVU));
        w_is_mf  = w_take && ((bus.op_funct == F_MFHI) || (bus.op_funct == F_MFLO));
        w_sgn    = is_signed_funct(bus.op_funct);
        w_rs_abs = (w_sgn && bus.rs_val[WIDTH-1]) ? (~bus.rs_val + WIDTH'(1)) : bus.rs_val;
        w_rt_abs = (w_sgn && bus.rt_val[WIDTH-1]) ? (~bus.rt_val + WIDTH'(1)) : bus.rt_val;
    end

    mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .i_div  (w_step_div),
        .i_acc  (r_acc),
        .i_q    (r_q),
        .i_opnd (r_opnd),
        .o_acc  (w_acc_nxt),
        .o_q    (w_q_nxt)
    );

    // Final sign correction; divide-by-zero keeps the raw all-ones quotient and
    // the sign-restored dividend as remainder, which equals the original rs.
    always_comb begin
        w_prod_neg = ~{r_acc, r_q} + (2*WIDTH)'(1);
        w_hi_fix   = r_acc;
        w_lo_fix   = r_q;
        if (r_is_div) begin
            if (r_dz) begin
                w_lo_fix = '1;
            end else if (r_neg_q) begin
                w_lo_fix = ~r_q + WIDTH'(1);
            end
            if (r_neg_r) begin
                w_hi_fix = ~r_acc + WIDTH'(1);
            end
        end else if (r_neg_q) begin
            w_hi_fix = w_prod_neg[2*WIDTH-1:WIDTH];
            w_lo_fix = w_prod_neg[WIDTH-1:0];
        end
    end

    // Next-state logic: IDLE -> MUL/DIV on accept, WIDTH steps, one FIX cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_is_mul) begin
                    w_state_nxt = ST_MUL;
                end else if (w_is_div) begin
                    w_state_nxt = ST_DIV;
                end
            end
            ST_MUL, ST_DIV: begin
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_state_nxt = ST_FIX;
                end
            end
            ST_FIX:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand latch, iteration datapath, HI/LO writeback and MFHI/MFLO result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_opnd    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_res_dat <= '0;
            r_res_rd  <= '0;
            r_res_vld <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dz      <= 1'b0;
            r_is_div  <= 1'b0;
        end else begin
            r_res_vld <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_is_mul || w_is_div) begin
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_q      <= w_is_mul ? w_rt_abs : w_rs_abs;
                        r_opnd   <= w_is_mul ? w_rs_abs : w_rt_abs;
                        r_neg_q  <= w_sgn && (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
                        r_neg_r  <= w_sgn && w_is_div && bus.rs_val[WIDTH-1];
                        r_dz     <= w_is_div && (bus.rt_val == '0);
                        r_is_div <= w_is_div;
                    end else if (w_is_mf) begin
                        r_res_vld <= 1'b1;
                        r_res_dat <= (bus.op_funct == F_MFHI) ? r_hi : r_lo;
                        r_res_rd  <= bus.rd;
                    end
                end
                ST_MUL, ST_DIV: begin
                    r_acc <= w_acc_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt + 1'b1;
                end
                ST_FIX: begin
                    r_hi <= w_hi_fix;
                    r_lo <= w_lo_fix;
                end
                default: ;
            endcase
        end
    end

    assign bus.op_ready    = (r_state == ST_IDLE);
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.res_valid   = r_res_vld;
    assign bus.res_data    = r_res_dat;
    assign bus.res_rd      = r_res_rd;
    assign bus.div_by_zero = (r_state == ST_FIX) && r_dz;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: directed MULT/DIV/MF vectors with hand-computed results.
// Latency: expects HI/LO after WIDTH+1 busy cycles and MF results one cycle after accept.
// Backpressure: stimulus holds op_valid until op_ready, with a bounded wait.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mdu_if #(.WIDTH(32)) bus ();

    mdu_ctrl #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit          is_mf;
        logic [31:0] a;     // HI for ops, res_data for MF
        logic [31:0] b;     // LO for ops
        logic [4:0]  rd;
        bit          dz;
    } exp_t;

    exp_t q_exp[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive a request and hold it until accepted; returns cycles spent stalled.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, output int wait_cyc);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op_funct = f;
        bus.rs_val   = a;
        bus.rt_val   = b;
        bus.rd       = d;
        wait_cyc     = 0;
        while (!bus.op_ready && wait_cyc < 200) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (!bus.op_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: op_ready still %0b after %0d cycles", bus.op_ready, wait_cyc);
        end
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
    endtask

    task automatic op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_hi, input logic [31:0] exp_lo, input bit exp_dz);
        int w;
        exp_t e;
        e.is_mf = 1'b0; e.a = exp_hi; e.b = exp_lo; e.rd = 5'd0; e.dz = exp_dz;
        q_exp.push_back(e);
        issue(f, a, b, 5'd0, w);
    endtask

    task automatic mf(input logic [5:0] f, input logic [4:0] d, input logic [31:0] exp_dat,
                      output int w);
        exp_t e;
        e.is_mf = 1'b1; e.a = exp_dat; e.b = 32'd0; e.rd = d; e.dz = 1'b0;
        q_exp.push_back(e);
        issue(f, 32'd0, 32'd0, d, w);
    endtask

    // Monitor: pops an expectation on every result pulse and every busy->idle completion.
    initial begin : monitor
        int   busy_cyc;
        int   dz_cnt;
        logic prev_busy;
        exp_t e;
        busy_cyc  = 0;
        dz_cnt    = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cyc  = 0;
                dz_cnt    = 0;
                prev_busy = 1'b0;
            end else begin
                if (bus.busy) busy_cyc++;
                if (bus.div_by_zero) dz_cnt++;
                if (bus.res_valid) begin
                    if (q_exp.size() == 0 || !q_exp[0].is_mf) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_res_valid: got res_data 0x%08h, expected no pulse", bus.res_data);
                    end else begin
                        e = q_exp.pop_front();
                        check32("res_data", bus.res_data, e.a);
                        check32("res_rd", 32'(bus.res_rd), 32'(e.rd));
                    end
                end
                if (prev_busy && !bus.busy) begin
                    if (q_exp.size() == 0 || q_exp[0].is_mf) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_completion: got hi 0x%08h lo 0x%08h, expected none", bus.hi, bus.lo);
                    end else begin
                        e = q_exp.pop_front();
                        check32("hi", bus.hi, e.a);
                        check32("lo", bus.lo, e.b);
                        check32("busy_cycles", 32'(busy_cyc), 32'd33);
                        check32("div_by_zero_pulses", 32'(dz_cnt), 32'(e.dz));
                    end
                    busy_cyc = 0;
                    dz_cnt   = 0;
                end
                prev_busy = bus.busy;
            end
        end
    end

    // Stimulus.
    initial begin : stim
        int w;
        bus.op_valid = 1'b0;
        bus.op_funct = 6'd0;
        bus.rs_val   = 32'd0;
        bus.rt_val   = 32'd0;
        bus.rd       = 5'd0;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check32("rst_op_ready", 32'(bus.op_ready), 32'd1);
        check32("rst_busy", 32'(bus.busy), 32'd0);
        check32("rst_hi", bus.hi, 32'd0);
        check32("rst_lo", bus.lo, 32'd0);
        check32("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check32("rst_res_data", bus.res_data, 32'd0);
        check32("rst_res_rd", 32'(bus.res_rd), 32'd0);
        check32("rst_div_by_zero", 32'(bus.div_by_zero), 32'd0);
        rst_n = 1'b1;

        op(F_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        op(F_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        op(F_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0);
        op(F_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         1'b0);
        op(F_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1);
        mf(F_MFHI, 5'd17, 32'd5, w);
        op(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);

        // MFLO held from the cycle after a MULT accept stalls through the whole op.
        op(F_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
        mf(F_MFLO, 5'd9, 32'd42, w);
        check32("mflo_stall_cycles", 32'(w), 32'd33);

        // Unknown funct is dropped: no state change, no pulse.
        issue(6'b100000, 32'd1, 32'd2, 5'd4, w);
        @(negedge clk);
        check32("ignored_busy", 32'(bus.busy), 32'd0);
        check32("ignored_op_ready", 32'(bus.op_ready), 32'd1);

        // Asynchronous reset in the middle of a divide.
        issue(F_DIVU, 32'd100, 32'd3, 5'd0, w);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check32("midrst_busy", 32'(bus.busy), 32'd0);
        check32("midrst_op_ready", 32'(bus.op_ready), 32'd1);
        check32("midrst_hi", bus.hi, 32'd0);
        check32("midrst_lo", bus.lo, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check32("postrst_op_ready", 32'(bus.op_ready), 32'd1);
        op(F_MULT, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
        mf(F_MFLO, 5'd1, 32'd6, w);

        w = 0;
        while (q_exp.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check32("scoreboard_drained", 32'(q_exp.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_chk);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit controller for the MIPS core. Sits beside the decode stage and owns the HI/LO register pair. It accepts MULT, MULTU, DIV, DIVU, MFHI and MFLO (SPECIAL opcode, selected by funct) and sequences a radix-2 iterative shift-add / restoring shift-subtract datapath over WIDTH cycles. It stalls the issuing stage while an operation is in flight.

## Interface
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- op_valid  in  1  decode presents an MDU instruction
- op_funct  in  6  funct field: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010000 MFHI, 010010 MFLO
- rs_val  in  WIDTH  rs operand (multiplicand / dividend)
- rt_val  in  WIDTH  rt operand (multiplier / divisor)
- rd  in  5  destination register for MFHI/MFLO
- op_ready  out  1  high only in IDLE; transfer occurs when op_valid && op_ready
- busy  out  1  high in MUL, DIV and FIX
- res_valid  out  1  one-cycle pulse carrying an MFHI/MFLO result
- res_data  out  WIDTH  HI or LO value for the pulse
- res_rd  out  5  rd captured with the MFHI/MFLO
- div_by_zero  out  1  one-cycle pulse when a DIV/DIVU with rt_val==0 completes
- hi, lo  out  WIDTH  architectural HI/LO

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE, accepted MULT/MULTU:
  - latch |rs|, |rt| (signed) or raw values (unsigned)
  - record result sign = sign(rs) XOR sign(rt) (MULT only)
  - count=0, go to MUL
- IDLE, accepted DIV/DIVU: same latch; quotient sign as above; remainder sign = sign(rs); go to DIV.
- IDLE, accepted MFHI/MFLO: register res_data=hi/lo, res_rd=rd, pulse res_valid next cycle; stay IDLE.
- IDLE, accepted other funct: ignored, no state change, no pulse.
- MUL: one shift-add step per cycle on a 2*WIDTH accumulator. After WIDTH steps (count==WIDTH-1), go to FIX.
- DIV: one restoring step per cycle. After WIDTH steps, go to FIX.
- FIX:
  - apply two's-complement negation per recorded signs
  - write HI=upper/remainder, LO=lower/quotient
  - go to IDLE
- Divide by zero: LO=all ones, HI=rs_val, no sign fixup, div_by_zero pulses in the FIX cycle.
- Signed overflow: 0x80000000 / -1 gives LO=0x80000000, HI=0 with no special case.
- Arithmetic is modulo 2*WIDTH for products and modulo WIDTH for fixups.

## Timing
- Accept at edge E0.
- HI/LO updated at edge E0+WIDTH+1: 33 cycles for WIDTH=32.
- op_ready goes low after E0. It returns high at E0+WIDTH+1, so the earliest next accept is E0+WIDTH+1.
- MFHI/MFLO: res_valid/res_data/res_rd valid in the cycle after acceptance.
- MFHI/MFLO issued while busy stall (op_ready=0) until IDLE, then return the updated value.
- No operation is accepted in FIX; no overlap, no cancellation.
- Reset (asynchronous, any state, including mid-iteration): state=IDLE, hi=lo=0, busy=0, res_valid=0, res_data=0, res_rd=0, div_by_zero=0, op_ready=1 while rst_n is low and after release.

## Structure
- Package mdu_pkg holds:
  - funct constants (MULT, MULTU, DIV, DIVU, MFHI, MFLO)
  - state enum (IDLE, MUL, DIV, FIX)
  - opcode SPECIAL=000000
- One sub-module, mdu_iter: combinational single-step shift-add / shift-subtract on {acc, operand}.
- mdu_ctrl holds the FSM, counter, sign flags and HI/LO.

## Test plan
- MULT rs=0xFFFFFFFD, rt=7 -> after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high exactly 33 cycles.
- MULTU rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
- DIVU 5/0 -> LO=0xFFFFFFFF, HI=5, one div_by_zero pulse; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MFLO rd=9 held valid from the cycle after a MULT 6*7 accept -> op_ready low 33 cycles, then accepted; next cycle res_valid=1, res_data=42, res_rd=9.
- rst_n low during DIV at iteration 10 -> immediately IDLE, busy=0, hi=lo=0; after release op_ready=1 and a new MULT 2*3 yields LO=6.
